// File: rtl/div_ctrl.sv
// EX-stage sequencer for the radix-2 divider: start pulse, stall, result hold, watchdog.
// Optional DIV_ZERO_BYPASS_EN resolves a zero divisor without starting the divider.
module div_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        div_req,
    input  logic        div_sign,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        pipe_stall,
    output logic        dv_valid,
    output logic        dv_flush,
    output logic [31:0] dv_a,
    output logic [31:0] dv_b,
    output logic        dv_sign,
    input  logic        dv_ready,
    input  logic [63:0] dv_result,
    output logic        stall_out,
    output logic        res_valid,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             start;
    logic             zero_byp;
    logic             wd_exp;

`ifdef DIV_ZERO_BYPASS_EN
    assign zero_byp = (op_b == 32'd0);
`else
    assign zero_byp = 1'b0;
`endif

    assign req    = rst & (state == IDLE) & div_req & ~flush;
    assign start  = req & ~zero_byp;
    // A ready arriving on the final watchdog cycle still wins.
    assign wd_exp = (state == BUSY) & ~dv_ready
                  & (cnt == CNT_W'(TIMEOUT - 1));

    assign dv_valid  = start;
    assign dv_flush  = rst & (flush | wd_exp);
    assign dv_a      = rst ? op_a : 32'd0;
    assign dv_b      = rst ? op_b : 32'd0;
    assign dv_sign   = rst & div_sign;
    assign stall_out = req | (state == BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_out    <= 32'd0;
            lo_out    <= 32'd0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        if (zero_byp) begin
                            hi_out    <= op_a;
                            lo_out    <= 32'hFFFF_FFFF;
                            res_valid <= 1'b1;
                            err       <= 1'b0;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (dv_ready) begin
                        hi_out    <= dv_result[63:32];
                        lo_out    <= dv_result[31:0];
                        res_valid <= 1'b1;
                        err       <= 1'b0;
                        state     <= DONE;
                    end else if (wd_exp) begin
                        hi_out    <= 32'd0;
                        lo_out    <= 32'd0;
                        res_valid <= 1'b1;
                        err       <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    cnt <= '0;
                    if (!pipe_stall) begin
                        res_valid <= 1'b0;
                        err       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Execute-stage sequencer for the radix-2 divider. It sits between the EX-stage DIV/DIVU decode and the divider instance.
- Issues a single-cycle start pulse, stalls the pipeline while the divide runs, and captures the {HI,LO} result into holding registers until the pipeline advances.
- Aborts the divide on exception flush and guards against a hung divider with a watchdog.

Parameters:
- TIMEOUT, 40, maximum BUSY cycles before the watchdog abort (must be greater than 34).
- CNT_W, 6, width of the watchdog counter (2^CNT_W > TIMEOUT).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  exception flush; squashes the divide in flight
- div_req  input  1  EX holds a DIV/DIVU; held high until EX advances
- div_sign  input  1  1 = DIV (signed), 0 = DIVU
- op_a  input  32  dividend
- op_b  input  32  divisor
- pipe_stall  input  1  a later stage stalls; EX cannot advance this cycle
- dv_valid  output  1  start pulse to divider valid
- dv_flush  output  1  to divider flush
- dv_a  output  32  to divider a
- dv_b  output  32  to divider b
- dv_sign  output  1  to divider sign
- dv_ready  input  1  divider ready (one-cycle pulse)
- dv_result  input  64  divider result {remainder, quotient}
- stall_out  output  1  stall request to the hazard unit
- res_valid  output  1  hi_out/lo_out hold a valid result for the instruction in EX
- hi_out  output  32  remainder
- lo_out  output  32  quotient
- err  output  1  watchdog abort occurred for the current result

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, watchdog counter = 0; hi_out = 0, lo_out = 0, res_valid = 0, err = 0. All combinational outputs evaluate to 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - When div_req & !flush: dv_valid = 1 for exactly this cycle; next state = BUSY.
  - dv_a/dv_b/dv_sign pass op_a/op_b/div_sign straight through; the divider latches them on this edge.
  - dv_valid must never be high in BUSY or DONE. The divider restarts if valid is high while it is idle.
- BUSY:
  - Watchdog counter increments each cycle.
  - When dv_ready: capture hi_out = dv_result[63:32] and lo_out = dv_result[31:0]; set res_valid = 1, err = 0; next state = DONE.
  - When the counter reaches TIMEOUT without dv_ready: dv_flush = 1 for one cycle; set hi_out = 0, lo_out = 0, res_valid = 1, err = 1; next state = DONE.
- DONE:
  - stall_out = 0; the result is held stable.
  - When !pipe_stall, EX advances this cycle: clear res_valid and err; next state = IDLE.
  - When pipe_stall: remain in DONE and hold the result. div_req still high here is the same instruction and must not restart.
- stall_out = (IDLE & div_req & !flush) | BUSY.
- Latency: request first seen in IDLE at cycle T → dv_ready at T+33 → DONE at T+34. stall_out is high for cycles T..T+33 (34 cycles).
- flush: dv_flush = flush in every state (combinational). Next state = IDLE; res_valid and err clear; the counter clears.
- flush has priority over a simultaneous div_req, dv_ready or watchdog expiry.
- A dv_ready received outside BUSY is ignored.
- div_req dropping during BUSY (not via flush) is ignored; the controller completes the divide.
- Back-to-back divides: DONE→IDLE followed by a new div_req starts the next divide in the first IDLE cycle with no idle bubble beyond that one.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- When defined: in IDLE, div_req & !flush & op_b == 0 does not start the divider (dv_valid stays 0). The controller goes directly to DONE with lo_out = 32'hFFFF_FFFF, hi_out = op_a, res_valid = 1, err = 0. stall_out is high for that one cycle only.
- When undefined: a zero divisor is issued to the divider like any other operand, and its result is captured as-is.

Test Plan:
- DIVU 100/7, pipe_stall = 0 → dv_valid pulse at T; stall_out high for 34 cycles; at T+34 res_valid = 1, lo_out = 14, hi_out = 2; IDLE at T+35.
- DIV 32'hFFFF_FFF9 (−7) / 2 → lo_out = 32'hFFFF_FFFD, hi_out = 32'hFFFF_FFFF. Also DIV 7 / −2 → lo_out = 32'hFFFF_FFFD, hi_out = 1.
- Start DIVU, assert flush at T+10 → dv_flush = 1 that cycle, state IDLE, res_valid = 0. A new DIVU 9/3 issued at T+12 yields lo_out = 3, hi_out = 0 with full 34-cycle latency.
- Result reaches DONE with pipe_stall = 1 for 5 cycles while div_req stays high → no second dv_valid; hi/lo stable; IDLE the cycle after pipe_stall drops.
- Tie dv_ready = 0 → at the TIMEOUT (40th) BUSY cycle dv_flush pulses; DONE with err = 1, res_valid = 1, hi_out = lo_out = 0.
- With DIV_ZERO_BYPASS_EN: DIVU 5/0 → no dv_valid; next cycle lo_out = 32'hFFFF_FFFF, hi_out = 5; stall_out high for 1 cycle. Without the macro → 34-cycle stall, dv_valid pulses once.
